// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS/DLX fetch stage owning the PC, plus the IF/ID pipeline register.
//   clock, reset (async, active-high)
//   stall                      - freeze PC, IF/ID, fetch_count and state
//   branch_sel/branch_address  - taken branch from decode
//   jump_sel/jump_address      - jump from decode (wins over branch)
//   imem_addr -> imem_data     - combinational instruction memory
//   instruc, current_PC        - IF/ID instruction and fetch PC + 1
//   if_valid                   - IF/ID holds a real instruction
//   halted                     - HALT opcode fetched, fetch stopped until reset
//   fetch_count                - valid instructions delivered to IF/ID
module instruction_fetch #(
    parameter int              PC_SIZE  = 31,
    parameter logic [PC_SIZE:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0000,
    parameter logic [5:0]      HALT_OP  = 6'b111111
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_sel,
    input  logic [PC_SIZE:0]   branch_address,
    input  logic               jump_sel,
    input  logic [PC_SIZE:0]   jump_address,
    output logic [PC_SIZE:0]   imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        instruc,
    output logic [PC_SIZE:0]   current_PC,
    output logic               if_valid,
    output logic               halted,
    output logic [31:0]        fetch_count
);
    typedef enum logic {RUN, HALT} state_t;
    state_t           state;
    logic [PC_SIZE:0] pc;
    logic [PC_SIZE:0] pc_inc;
    logic [PC_SIZE:0] target;
    logic             redirect;
    logic             is_halt;
    assign pc_inc    = pc + 1'b1;
    assign target    = jump_sel ? jump_address : branch_address;
    assign redirect  = !stall && (jump_sel || branch_sel);
    assign is_halt   = imem_data[31:26] == HALT_OP;
    assign imem_addr = pc;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instruc     <= NOP;
            current_PC  <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else if (!stall) begin
            if (state == HALT) begin
                instruc  <= NOP;
                if_valid <= 1'b0;
            end else if (redirect) begin
                // Squash the word fetched this cycle; a HALT word here is wrong-path and ignored.
                pc       <= target;
                instruc  <= NOP;
                if_valid <= 1'b0;
            end else begin
                instruc     <= imem_data;
                current_PC  <= pc_inc;
                if_valid    <= 1'b1;
                fetch_count <= fetch_count + 1'b1;
                if (is_halt) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized and directed checks of instruction_fetch against a spec-level model.
module tb_instruction_fetch;
    localparam int PS = 5;
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          branch_sel = 1'b0;
    logic [PS:0]   branch_address = '0;
    logic          jump_sel = 1'b0;
    logic [PS:0]   jump_address = '0;
    logic [PS:0]   imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   instruc;
    logic [PS:0]   current_PC;
    logic          if_valid;
    logic          halted;
    logic [31:0]   fetch_count;
    logic [31:0]   mem [64];
    int            vectors = 0;
    int            errors = 0;
    logic [PS:0]   m_pc;
    logic [31:0]   m_ins;
    logic [PS:0]   m_cur;
    logic          m_v;
    logic          m_halt;
    logic [31:0]   m_cnt;
    logic [31:0]   held;

    instruction_fetch #(.PC_SIZE(PS)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_sel(branch_sel), .branch_address(branch_address),
        .jump_sel(jump_sel), .jump_address(jump_address),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instruc(instruc), .current_PC(current_PC), .if_valid(if_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    assign imem_data = mem[imem_addr];
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".imem_addr"}, 64'(imem_addr), 64'(m_pc));
        check({tag, ".instruc"}, 64'(instruc), 64'(m_ins));
        check({tag, ".current_PC"}, 64'(current_PC), 64'(m_cur));
        check({tag, ".if_valid"}, 64'(if_valid), 64'(m_v));
        check({tag, ".halted"}, 64'(halted), 64'(m_halt));
        check({tag, ".fetch_count"}, 64'(fetch_count), 64'(m_cnt));
    endtask

    // Model of one rising edge, using the inputs as they stand just before it.
    task automatic model_edge();
        logic [31:0] w;
        w = mem[m_pc];
        if (stall) return;
        if (m_halt) begin
            m_ins = 32'h0;
            m_v   = 1'b0;
        end else if (jump_sel || branch_sel) begin
            m_pc  = jump_sel ? jump_address : branch_address;
            m_ins = 32'h0;
            m_v   = 1'b0;
        end else begin
            m_ins = w;
            m_cur = m_pc + 6'd1;
            m_v   = 1'b1;
            m_cnt = m_cnt + 32'd1;
            if (w[31:26] == 6'h3f) m_halt = 1'b1;
            else m_pc = m_pc + 6'd1;
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        m_pc = '0; m_ins = '0; m_cur = '0; m_v = 0; m_halt = 0; m_cnt = '0;
        compare_all(tag);
        reset = 1'b0;
    endtask

    task automatic idle();
        stall = 0; branch_sel = 0; jump_sel = 0;
    endtask

    task automatic seq_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    endtask

    initial begin
        seq_mem();
        do_reset("reset");
        check("reset.instruc_nop", 64'(instruc), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick("seq");
            check("seq.word", 64'(instruc), 64'(32'h1000_0000 + i));
            check("seq.cur", 64'(current_PC), 64'(i + 1));
            check("seq.valid", 64'(if_valid), 64'd1);
        end
        check("seq.count4", 64'(fetch_count), 64'd4);

        branch_sel = 1; branch_address = 6'd20;
        tick("branch");
        check("branch.bubble", 64'(instruc), 64'h0);
        check("branch.valid0", 64'(if_valid), 64'd0);
        check("branch.addr", 64'(imem_addr), 64'd20);
        idle();
        tick("branch_tgt");
        check("branch_tgt.word", 64'(instruc), 64'h1000_0014);
        check("branch_tgt.cur", 64'(current_PC), 64'd21);
        check("branch_tgt.count", 64'(fetch_count), 64'd5);

        jump_sel = 1; jump_address = 6'd40; branch_sel = 1; branch_address = 6'd20;
        tick("jump_wins");
        check("jump_wins.addr", 64'(imem_addr), 64'd40);
        stall = 1; jump_address = 6'd12;
        held = instruc;
        tick("jump_stalled");
        check("jump_stalled.addr", 64'(imem_addr), 64'd40);
        check("jump_stalled.instr", 64'(instruc), 64'(held));
        idle();

        do_reset("reset2");
        for (int i = 0; i < 7; i++) tick("to7");
        stall = 1;
        held = instruc;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.addr", 64'(imem_addr), 64'd7);
            check("stall.instr", 64'(instruc), 64'(held));
        end
        stall = 0;
        tick("unstall");
        check("unstall.word", 64'(instruc), 64'h1000_0007);
        check("unstall.count", 64'(fetch_count), 64'd8);

        mem[5] = 32'hFC00_0005;
        do_reset("reset3");
        for (int i = 0; i < 6; i++) tick("to_halt");
        check("halt.word", 64'(instruc), 64'hFC00_0005);
        check("halt.halted", 64'(halted), 64'd1);
        check("halt.addr", 64'(imem_addr), 64'd5);
        branch_sel = 1; branch_address = 6'd9; jump_sel = 1; jump_address = 6'd11;
        for (int i = 0; i < 2; i++) begin
            tick("halted");
            check("halted.nop", 64'(instruc), 64'h0);
            check("halted.valid0", 64'(if_valid), 64'd0);
            check("halted.addr", 64'(imem_addr), 64'd5);
        end
        idle();
        do_reset("reset4");
        check("reset4.addr", 64'(imem_addr), 64'd0);
        check("reset4.halted", 64'(halted), 64'd0);
        seq_mem();

        branch_sel = 1; branch_address = 6'd63;
        tick("to63");
        idle();
        tick("wrap");
        check("wrap.addr", 64'(imem_addr), 64'd0);
        check("wrap.cur", 64'(current_PC), 64'd0);

        mem[10] = 32'hFC00_000A;
        branch_sel = 1; branch_address = 6'd10;
        tick("to10");
        branch_address = 6'd30;
        tick("squash");
        check("squash.halted", 64'(halted), 64'd0);
        check("squash.addr", 64'(imem_addr), 64'd30);
        idle();

        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 99) < 4) ? {6'h3f, 26'($urandom)} : $urandom;
        do_reset("rand_reset");
        for (int n = 0; n < 2000; n++) begin
            stall          = $urandom_range(0, 99) < 25;
            branch_sel     = $urandom_range(0, 99) < 10;
            jump_sel       = $urandom_range(0, 99) < 5;
            branch_address = 6'($urandom);
            jump_address   = 6'($urandom);
            if ($urandom_range(0, 99) < 2) do_reset("rand_async_reset");
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
